// File: rtl/wb_sram_target.sv
// Wishbone B4 registered-feedback SRAM target supporting classic, constant-address and
// incrementing (linear/wrap4/wrap8/wrap16) bursts; upper address bits alias.
module wb_sram_target #(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter int MEM_ADDR_BITS = 10,
    parameter bit READ_ONLY     = 1'b0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [WB_ADDR_WIDTH-1:0]   ADR,
    input  logic [WB_DATA_WIDTH-1:0]   DAT_W,
    output logic [WB_DATA_WIDTH-1:0]   DAT_R,
    input  logic [WB_DATA_WIDTH/8-1:0] SEL,
    input  logic                       CYC,
    input  logic                       STB,
    input  logic                       WE,
    input  logic [2:0]                 CTI,
    input  logic [1:0]                 BTE,
    output logic                       ACK,
    output logic                       ERR
);
    localparam int NUM_LANES = WB_DATA_WIDTH / 8;
    localparam int LSB       = $clog2(NUM_LANES);
    localparam int DEPTH     = 1 << MEM_ADDR_BITS;

    typedef enum logic [1:0] {IDLE, SINGLE, BURST, ERRS} state_t;

    state_t                     state_q, state_d;
    logic                       ack_q, ack_d;
    logic                       err_q, err_d;
    logic [MEM_ADDR_BITS-1:0]   idx_q, idx_d;
    logic [WB_DATA_WIDTH-1:0]   dat_r_q, dat_r_d;

    logic [WB_DATA_WIDTH-1:0]   mem [DEPTH];

    logic [MEM_ADDR_BITS-1:0]   word_idx, nidx, wrap_mask, rd_addr, wr_addr;
    logic                       beat, cti_reserved, wr_en, load;
    logic [WB_DATA_WIDTH-1:0]   wr_merged, rd_data;
    logic                       unused_adr;

    assign word_idx     = ADR[MEM_ADDR_BITS+LSB-1:LSB];
    assign unused_adr   = ^ADR;
    assign beat         = ack_q & CYC & STB;
    assign cti_reserved = (CTI == 3'b011) || (CTI == 3'b100) || (CTI == 3'b101) || (CTI == 3'b110);

    // Wrapping bursts only advance the low bits selected by the mask; the rest are kept.
    always_comb begin
        unique case (BTE)
            2'b01:   wrap_mask = MEM_ADDR_BITS'(4'h3);
            2'b10:   wrap_mask = MEM_ADDR_BITS'(4'h7);
            2'b11:   wrap_mask = MEM_ADDR_BITS'(4'hF);
            default: wrap_mask = '1;
        endcase
        if (CTI == 3'b001) begin
            nidx = idx_q;
        end else begin
            nidx = (idx_q & ~wrap_mask) | ((idx_q + MEM_ADDR_BITS'(1)) & wrap_mask);
        end
    end

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        err_d   = err_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        load    = 1'b0;
        wr_addr = idx_q;
        rd_addr = idx_q;
        if (!CYC) begin
            state_d = IDLE;
            ack_d   = 1'b0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (STB) begin
                        if (cti_reserved || (WE && READ_ONLY)) begin
                            err_d   = 1'b1;
                            state_d = ERRS;
                        end else begin
                            ack_d   = 1'b1;
                            wr_en   = WE;
                            wr_addr = word_idx;
                            rd_addr = word_idx;
                            load    = 1'b1;
                            if ((CTI == 3'b001) || (CTI == 3'b010)) begin
                                state_d = BURST;
                                idx_d   = word_idx;
                            end else begin
                                state_d = SINGLE;
                            end
                        end
                    end
                end
                SINGLE: begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
                BURST: begin
                    // A wait state (STB low) leaves idx, DAT_R and ack_q untouched.
                    if (beat) begin
                        wr_en   = WE & ~READ_ONLY;
                        wr_addr = idx_q;
                        if (CTI == 3'b111) begin
                            ack_d   = 1'b0;
                            state_d = IDLE;
                        end else begin
                            idx_d   = nidx;
                            rd_addr = nidx;
                            load    = 1'b1;
                        end
                    end
                end
                ERRS: begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Write-first bypass: a read of the word being written returns the merged lanes.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            wr_merged[8*l +: 8] = SEL[l] ? DAT_W[8*l +: 8] : mem[wr_addr][8*l +: 8];
        end
        rd_data = (wr_en && (rd_addr == wr_addr)) ? wr_merged : mem[rd_addr];
        dat_r_d = load ? rd_data : dat_r_q;
    end

    always_ff @(posedge clk) begin
        if (rstn && wr_en) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (SEL[l]) begin
                    mem[wr_addr][8*l +: 8] <= DAT_W[8*l +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            dat_r_q <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            dat_r_q <= dat_r_d;
        end
    end

    assign ACK   = ack_q & CYC & STB;
    assign ERR   = err_q & CYC & STB;
    assign DAT_R = dat_r_q;
endmodule

// File: tb/tb_wb_sram_target.sv
// Directed bench for wb_sram_target: a read/write instance plus a READ_ONLY instance
// sharing one master; read data is predicted into a queue and checked on ACK.
module tb_wb_sram_target;
    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] adr, dat_w;
    logic [3:0]  sel;
    logic        cyc, stb, we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ro_sel;

    logic [31:0] dat_r0, dat_r1, dat_r;
    logic        ack0, ack1, err0, err1, ack, err;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] beat_data[4];
    logic [31:0] beat_exp[4];
    logic [31:0] prior;

    always #5 clk = ~clk;

    assign dat_r = ro_sel ? dat_r1 : dat_r0;
    assign ack   = ro_sel ? ack1 : ack0;
    assign err   = ro_sel ? err1 : err0;

    wb_sram_target u_dut (
        .clk(clk), .rstn(rstn), .ADR(adr), .DAT_W(dat_w), .DAT_R(dat_r0), .SEL(sel),
        .CYC(cyc & ~ro_sel), .STB(stb), .WE(we), .CTI(cti), .BTE(bte), .ACK(ack0), .ERR(err0)
    );

    wb_sram_target #(.READ_ONLY(1'b1)) u_ro (
        .clk(clk), .rstn(rstn), .ADR(adr), .DAT_W(dat_w), .DAT_R(dat_r1), .SEL(sel),
        .CYC(cyc & ro_sel), .STB(stb), .WE(we), .CTI(cti), .BTE(bte), .ACK(ack1), .ERR(err1)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_output(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected <empty scoreboard>", tag, dat_r);
        end else begin
            e = exp_q.pop_front();
            check(tag, dat_r, e);
        end
    endtask

    task automatic apply_stimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                  input logic [3:0] s, input logic [2:0] c, input logic [1:0] b);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s; cti = c; bte = b;
    endtask

    task automatic idle_bus();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_w = '0; sel = '0; cti = '0; bte = '0;
    endtask

    task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [31:0] expv, input string tag);
        @(posedge clk); #1;
        apply_stimulus(w, a, d, s, 3'b000, 2'b00);
        if (!w) exp_q.push_back(expv);
        @(negedge clk);
        check({tag, " req ack"}, 32'(ack), 32'd0);
        @(negedge clk);
        check({tag, " ack"}, 32'(ack), 32'd1);
        check({tag, " err"}, 32'(err), 32'd0);
        if (!w) check_output({tag, " data"});
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        check({tag, " ack after"}, 32'(ack), 32'd0);
    endtask

    task automatic err_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [2:0] c, input string tag);
        @(posedge clk); #1;
        apply_stimulus(w, a, d, 4'hF, c, 2'b00);
        @(negedge clk);
        check({tag, " req err"}, 32'(err), 32'd0);
        @(negedge clk);
        check({tag, " err"}, 32'(err), 32'd1);
        check({tag, " ack"}, 32'(ack), 32'd0);
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        check({tag, " err after"}, 32'(err), 32'd0);
    endtask

    // Four-beat incrementing burst; optional STB-low gap after beat index gap_after.
    task automatic burst(input logic w, input logic [31:0] start, input logic [1:0] b,
                         input int gap_after, input int gap_len, input string tag);
        @(posedge clk); #1;
        apply_stimulus(w, start, beat_data[0], 4'hF, 3'b010, b);
        if (!w) exp_q.push_back(beat_exp[0]);
        @(negedge clk);
        check({tag, " req ack"}, 32'(ack), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("%s beat%0d ack", tag, k), 32'(ack), 32'd1);
            check($sformatf("%s beat%0d err", tag, k), 32'(err), 32'd0);
            if (!w) check_output($sformatf("%s beat%0d data", tag, k));
            @(posedge clk); #1;
            if (k == 3) begin
                idle_bus();
            end else begin
                if (k == gap_after) begin
                    stb = 1'b0;
                    dat_w = 32'hBAD0BAD0;
                    for (int g = 0; g < gap_len; g++) begin
                        @(negedge clk);
                        check($sformatf("%s gap%0d ack", tag, g), 32'(ack), 32'd0);
                        @(posedge clk); #1;
                    end
                end
                apply_stimulus(w, start + 32'(4 * (k + 1)), beat_data[k + 1], 4'hF,
                               (k == 2) ? 3'b111 : 3'b010, b);
                if (!w) exp_q.push_back(beat_exp[k + 1]);
            end
        end
        @(negedge clk);
        check({tag, " ack after"}, 32'(ack), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        ro_sel = 1'b0;
        idle_bus();
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("reset dat_r", dat_r, 32'h0);
        check("reset ack", 32'(ack), 32'd0);
        check("reset err", 32'(err), 32'd0);

        classic(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, "classic wr");
        classic(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, "classic rd");

        classic(1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, "lane preload");
        classic(1'b1, 32'h20, 32'h0000AB00, 4'b0010, 32'h0, "lane wr");
        classic(1'b0, 32'h20, 32'h0, 4'hF, 32'h1122AB44, "lane rd");

        for (int i = 0; i < 4; i++) begin
            classic(1'b1, 32'h10 + 32'(4 * i), 32'hA4 + 32'(i), 4'hF, 32'h0, "wrap4 preload");
        end
        beat_data = '{32'h0, 32'h0, 32'h0, 32'h0};
        beat_exp  = '{32'hA6, 32'hA7, 32'hA4, 32'hA5};
        burst(1'b0, 32'h18, 2'b01, -1, 0, "wrap4 rd");

        beat_data = '{32'd1, 32'd2, 32'd3, 32'd4};
        burst(1'b1, 32'h40, 2'b00, 1, 2, "lin wr gap");
        for (int i = 0; i < 4; i++) begin
            classic(1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'hF, 32'(i + 1), "lin readback");
        end

        beat_data = '{32'd5, 32'd6, 32'd7, 32'd8};
        burst(1'b1, 32'h50, 2'b00, -1, 0, "lin wr");
        beat_data = '{32'h0, 32'h0, 32'h0, 32'h0};
        beat_exp  = '{32'd7, 32'd8, 32'd1, 32'd2};
        burst(1'b0, 32'h58, 2'b10, -1, 0, "wrap8 rd");

        err_access(1'b0, 32'h10, 32'h0, 3'b011, "reserved cti");

        ro_sel = 1'b1;
        @(posedge clk); #1;
        apply_stimulus(1'b0, 32'h0, 32'h0, 4'hF, 3'b000, 2'b00);
        @(negedge clk);
        @(negedge clk);
        check("ro prior ack", 32'(ack), 32'd1);
        prior = dat_r;
        @(posedge clk); #1;
        idle_bus();
        err_access(1'b1, 32'h0, 32'h55, 3'b000, "ro write");
        classic(1'b0, 32'h0, 32'h0, 4'hF, prior, "ro readback");
        ro_sel = 1'b0;

        classic(1'b1, 32'h84, 32'h0BAD0033, 4'hF, 32'h0, "rst preload");
        @(posedge clk); #1;
        apply_stimulus(1'b1, 32'h80, 32'h11110001, 4'hF, 3'b010, 2'b00);
        @(negedge clk);
        check("rst req ack", 32'(ack), 32'd0);
        @(negedge clk);
        check("rst beat1 ack", 32'(ack), 32'd1);
        @(posedge clk); #1;
        apply_stimulus(1'b1, 32'h84, 32'h22220002, 4'hF, 3'b010, 2'b00);
        rstn = 1'b0;
        @(negedge clk);
        check("rst beat2 ack", 32'(ack), 32'd1);
        @(posedge clk); #1;
        rstn = 1'b1;
        apply_stimulus(1'b0, 32'h80, 32'h0, 4'hF, 3'b000, 2'b00);
        exp_q.push_back(32'h11110001);
        @(negedge clk);
        check("rst ack cleared", 32'(ack), 32'd0);
        @(negedge clk);
        check("rst new rd ack", 32'(ack), 32'd1);
        check_output("rst beat1 retained");
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        check("rst new rd ack after", 32'(ack), 32'd0);
        classic(1'b0, 32'h84, 32'h0, 4'hF, 32'h0BAD0033, "rst aborted beat");

        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL scoreboard drain: observed %0d left expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wb_sram_target.md
# wb_sram_target

Wishbone B4 registered-feedback SRAM target with classic, constant-address and incrementing/wrapping burst support. It attaches to one slave port (s0/s1/s2) of the Wishbone interconnect and is the memory endpoint for a decoded address window. The interconnect handles address decode, so this block uses only the low word-index bits of ADR. Upper address bits alias.

## Interface
Parameters:
- WB_ADDR_WIDTH, 32, address width.
- WB_DATA_WIDTH, 32, data width; multiple of 8.
- MEM_ADDR_BITS, 10, log2 of memory depth in words.
- READ_ONLY, 0, when 1 every write access is terminated with ERR.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- ADR  in  WB_ADDR_WIDTH  byte address. Word index = ADR[MEM_ADDR_BITS+LSB-1:LSB], where LSB = $clog2(WB_DATA_WIDTH/8).
- DAT_W  in  WB_DATA_WIDTH  write data.
- DAT_R  out  WB_DATA_WIDTH  read data.
- SEL  in  WB_DATA_WIDTH/8  byte-lane enables.
- CYC, STB, WE  in  1  Wishbone cycle, strobe and write-enable.
- CTI  in  3  cycle type: 000 classic, 001 constant, 010 incrementing, 111 end-of-burst.
- BTE  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- ACK, ERR  out  1  termination signals.

## Operation
- Storage is a word array of 2^MEM_ADDR_BITS entries with a synchronous read port and a per-byte write port. Memory is not reset.
- Internal registers:
  - idx: current word index.
  - ack_r, err_r: registered terminations.
  - state: IDLE, SINGLE, BURST, ERRS.
- Output qualification: ACK = ack_r & CYC & STB; ERR = err_r & CYC & STB.
- A beat completes on any clock edge where ACK=1.
- IDLE, on CYC&STB:
  - Reserved CTI (011..110), or WE=1 with READ_ONLY=1: set err_r and go to ERRS. Memory is not touched.
  - CTI=000 or 111: go to SINGLE, set ack_r, and load DAT_R <= mem[word index]. If WE=1, write the lanes with SEL=1 from DAT_W on this edge.
  - CTI=001 or 010: same actions as SINGLE, but go to BURST. idx <= word index.
- SINGLE: clear ack_r and return to IDLE. A new request is only sampled in IDLE, so classic throughput is 2 cycles per access.
- BURST, on each completed beat:
  - If CTI=111, or CYC=0, clear ack_r and go to IDLE.
  - Otherwise compute the next index nidx. CTI=001 keeps idx. CTI=010 advances by BTE:
    - linear: idx+1 modulo 2^MEM_ADDR_BITS.
    - wrap4: idx[1:0]+1, upper bits kept.
    - wrap8: idx[2:0]+1, upper bits kept.
    - wrap16: idx[3:0]+1, upper bits kept.
  - Set idx <= nidx and DAT_R <= mem[nidx].
  - Writes on a beat: the lanes selected by SEL are written from DAT_W to the current idx. A read of nidx==idx in the same cycle returns the newly written data (write-first).
  - ack_r stays 1.
- BURST with STB=0 (master wait state): ACK is 0 through qualification. idx and DAT_R are held, ack_r stays 1, and the burst resumes when STB returns to 1.
- ERRS: clear err_r and return to IDLE.
- CYC=0 in any state: next state IDLE, ack_r=0, err_r=0.
- Reset: state IDLE, ack_r 0, err_r 0, DAT_R 0, idx 0.

## Timing
- Request sampled at edge n: ACK or ERR is visible in cycle n+1, and DAT_R is valid in the same cycle as ACK.
- Burst: one beat per cycle after the first. An N-beat burst with no wait states occupies N+1 cycles, request cycle included.
- Writes take effect at the completing edge. A read in the next cycle returns the new data.
- ERR is asserted for exactly one cycle. ACK and ERR are never asserted together.
- Reset mid-operation: at the next edge ack_r and err_r are 0. Words already written remain. The aborted beat is not written.

## Test plan
- Classic write: 0xDEADBEEF to ADR 0x10, SEL=1111, then a classic read of ADR 0x10. Required: ACK exactly 1 cycle after STB; DAT_R=0xDEADBEEF; ACK low the following cycle.
- Byte lanes: preload 0x11223344 at ADR 0x20, then write 0x0000AB00 with SEL=0010. Required: read-back is 0x1122AB44.
- Wrap4 read burst: words 4..7 preloaded with 0xA4..0xA7, start at ADR 0x18, CTI=010, BTE=01, last beat CTI=111. Required: ACK high 4 consecutive cycles; DAT_R sequence 0xA6, 0xA7, 0xA4, 0xA5; ACK 0 afterward.
- Linear write burst of 4 beats from ADR 0x40, data 1..4, with STB low for 2 cycles after beat 2. Required: ACK low during the gap; no write during the gap; read-back of 0x40..0x4C gives 1, 2, 3, 4.
- Error terminations:
  - CTI=011 read. Required: ERR for 1 cycle, ACK stays 0.
  - READ_ONLY=1, write 0x55 to ADR 0x0. Required: ERR for 1 cycle; a subsequent read returns the prior contents.
- Reset mid-burst: rstn low for 1 cycle during beat 2 of an incrementing write burst. Required: ACK 0 next cycle; beat 1 data retained; a new classic read succeeds with ACK at n+1.
